// File: rtl/risc_toy_pkg.sv
// Shared RISC_TOY definitions: datapath widths, opcode encodings and branch-condition codes.
// Imported by the fetch front end and the later pipeline stages.
package risc_toy_pkg;

    localparam int RT_AW = 30;
    localparam int RT_DW = 32;

    typedef enum logic [4:0] {
        OP_ADDI = 5'd0,
        OP_ANDI = 5'd1,
        OP_ORI  = 5'd2,
        OP_MOVI = 5'd3,
        OP_ADD  = 5'd4,
        OP_SUB  = 5'd5,
        OP_NEG  = 5'd6,
        OP_NOT  = 5'd7,
        OP_AND  = 5'd8,
        OP_OR   = 5'd9,
        OP_XOR  = 5'd10,
        OP_LSR  = 5'd11,
        OP_ASR  = 5'd12,
        OP_SHL  = 5'd13,
        OP_ROR  = 5'd14,
        OP_BR   = 5'd15,
        OP_BRL  = 5'd16,
        OP_J    = 5'd17,
        OP_JL   = 5'd18,
        OP_LD   = 5'd19,
        OP_LDR  = 5'd20,
        OP_ST   = 5'd21,
        OP_STR  = 5'd22
    } opcode_e;

    typedef enum logic [2:0] {
        COND_NEVER   = 3'd0,
        COND_ALWAYS  = 3'd1,
        COND_ZERO    = 3'd2,
        COND_NONZERO = 3'd3,
        COND_GE0     = 3'd4,
        COND_LT0     = 3'd5
    } cond_e;

endpackage

// File: rtl/risc_toy_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, EX redirect and the decode handshake.
interface risc_toy_fetch_if
    import risc_toy_pkg::*;
#(
    parameter int AW = RT_AW,
    parameter int DW = RT_DW
);
    logic          IREQ;
    logic [AW-1:0] IADDR;
    logic [DW-1:0] INSTR;
    logic          REDIR_VALID;
    logic [AW-1:0] REDIR_ADDR;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [DW-1:0] OUT_INSTR;
    logic [AW-1:0] OUT_PC;

    modport master (
        output IREQ, IADDR, OUT_VALID, OUT_INSTR, OUT_PC,
        input  INSTR, REDIR_VALID, REDIR_ADDR, OUT_READY
    );

    modport slave (
        input  IREQ, IADDR, OUT_VALID, OUT_INSTR, OUT_PC,
        output INSTR, REDIR_VALID, REDIR_ADDR, OUT_READY
    );
endinterface

// File: rtl/risc_toy_fetch_queue.sv
// In-order instruction queue for the fetch stage: synchronous FIFO with push/pop and a
// dominant flush; the count output lets the fetch logic throttle requests.
module risc_toy_fetch_queue #(
    parameter  int WIDTH = 62,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against full/empty so the pointers can never be corrupted.
    always_comb begin
        do_push_s = push & (count_r != DEPTH_C);
        do_pop_s  = pop  & (count_r != {CW{1'b0}});
    end

    // Storage, pointers and occupancy; reset and flush take priority over traffic.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/risc_toy_fetch.sv
// RISC_TOY instruction-fetch front end: owns the PC, issues one fetch per cycle while the
// queue has room, queues returning instructions and hands them to decode; EX redirects flush.
module risc_toy_fetch
    import risc_toy_pkg::*;
#(
    parameter int AW    = RT_AW,
    parameter int DW    = RT_DW,
    parameter int DEPTH = 4
) (
    input logic               CLK,
    input logic               RST,
    risc_toy_fetch_if.master  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [AW-1:0]    pc_r;
    logic [AW-1:0]    req_addr_r;
    logic             inflight_r;
    logic             kill_r;
    logic             rst_q_r;

    logic [CW-1:0]    count_s;
    logic [AW+DW-1:0] head_s;
    logic [CW:0]      occ_s;
    logic             out_valid_s;
    logic             pop_s;
    logic             ireq_s;
    logic             q_push_s;
    logic             q_pop_s;
    logic             q_flush_s;

    // Issue decision: occupancy counts queued entries plus the fetch still in flight.
    always_comb begin
        out_valid_s = (count_s != {CW{1'b0}});
        pop_s       = out_valid_s & bus.OUT_READY;
        occ_s       = {1'b0, count_s} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
        ireq_s      = ~rst_q_r & ~bus.REDIR_VALID & (occ_s < DEPTH_C);
        q_flush_s   = bus.REDIR_VALID;
        q_push_s    = inflight_r & ~kill_r & ~bus.REDIR_VALID;
        q_pop_s     = pop_s & ~bus.REDIR_VALID;
    end

    // PC, outstanding-request tracking and response kill after a redirect.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rst_q_r    <= 1'b1;
            pc_r       <= {AW{1'b0}};
            req_addr_r <= {AW{1'b0}};
            inflight_r <= 1'b0;
            kill_r     <= 1'b0;
        end else begin
            rst_q_r <= 1'b0;
            if (bus.REDIR_VALID) begin
                pc_r       <= bus.REDIR_ADDR;
                kill_r     <= inflight_r;
                inflight_r <= 1'b0;
            end else begin
                kill_r <= 1'b0;
                if (ireq_s) begin
                    pc_r       <= pc_r + 1'b1;
                    req_addr_r <= pc_r;
                    inflight_r <= 1'b1;
                end else begin
                    inflight_r <= 1'b0;
                end
            end
        end
    end

    risc_toy_fetch_queue #(
        .WIDTH (AW + DW),
        .DEPTH (DEPTH)
    ) u_queue (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (q_flush_s),
        .push      (q_push_s),
        .push_data ({req_addr_r, bus.INSTR}),
        .pop       (q_pop_s),
        .head_data (head_s),
        .count     (count_s)
    );

    // Only a valid head is ever shown to decode; an empty queue presents zeros.
    always_comb begin
        if (out_valid_s) begin
            bus.OUT_PC    = head_s[AW+DW-1:DW];
            bus.OUT_INSTR = head_s[DW-1:0];
        end else begin
            bus.OUT_PC    = {AW{1'b0}};
            bus.OUT_INSTR = {DW{1'b0}};
        end
    end

    assign bus.IREQ      = ireq_s;
    assign bus.IADDR     = pc_r;
    assign bus.OUT_VALID = out_valid_s;

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Directed bench for risc_toy_fetch: a one-cycle memory returns mem[n]=n and each scenario
// checks cycle-exact request, queue and handshake behaviour against hand-computed values.
module tb_risc_toy_fetch;
    import risc_toy_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    int   n_checks = 0;
    int   n_pass   = 0;

    risc_toy_fetch_if #(.AW(RT_AW), .DW(RT_DW)) bus ();

    risc_toy_fetch #(.AW(RT_AW), .DW(RT_DW), .DEPTH(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Instruction memory model: data for the sampled request arrives one cycle later.
    always @(posedge CLK) begin
        bus.INSTR <= bus.IREQ ? {2'b00, bus.IADDR} : 32'hFFFF_FFFF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Two reset edges, check the post-reset cycle, release; returns at the start of cycle 0.
    task automatic do_reset(input logic rdy);
        bus.OUT_READY   = rdy;
        bus.REDIR_VALID = 1'b0;
        bus.REDIR_ADDR  = 30'h0;
        RST             = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
        check("rst_ireq",  32'(bus.IREQ),      32'h0);
        check("rst_valid", 32'(bus.OUT_VALID), 32'h0);
        check("rst_iaddr", 32'(bus.IADDR),     32'h0);
        check("rst_pc",    32'(bus.OUT_PC),    32'h0);
        check("rst_instr", bus.OUT_INSTR,      32'h0);
        tick();
    endtask

    initial begin
        RST             = 1'b1;
        bus.OUT_READY   = 1'b0;
        bus.REDIR_VALID = 1'b0;
        bus.REDIR_ADDR  = 30'h0;

        // Streaming with decode always ready.
        do_reset(1'b1);
        for (int c = 0; c < 8; c++) begin
            #1;
            check("t1_ireq",  32'(bus.IREQ),      32'h1);
            check("t1_iaddr", 32'(bus.IADDR),     32'(c));
            check("t1_valid", 32'(bus.OUT_VALID), 32'(c >= 2));
            if (c >= 2) begin
                check("t1_pc",    32'(bus.OUT_PC), 32'(c - 2));
                check("t1_instr", bus.OUT_INSTR,   32'(c - 2));
            end
            tick();
        end

        // Backpressure from cycle 2 to 11, then release.
        do_reset(1'b1);
        for (int c = 0; c < 20; c++) begin
            bus.OUT_READY = (c < 2) || (c >= 12);
            #1;
            check("t2_ireq",  32'(bus.IREQ),  32'((c < 4) || (c >= 12)));
            check("t2_iaddr", 32'(bus.IADDR), 32'((c < 4) ? c : ((c < 12) ? 4 : c - 8)));
            if (c < 2) begin
                check("t2_valid0", 32'(bus.OUT_VALID), 32'h0);
            end else if (c < 12) begin
                check("t2_valid_hold", 32'(bus.OUT_VALID), 32'h1);
                check("t2_pc_hold",    32'(bus.OUT_PC),    32'h0);
            end else begin
                check("t2_valid_run", 32'(bus.OUT_VALID), 32'h1);
                check("t2_pc_run",    32'(bus.OUT_PC),    32'(c - 12));
                check("t2_instr_run", bus.OUT_INSTR,      32'(c - 12));
            end
            tick();
        end

        // Redirect in cycle 5 with a fetch in flight.
        do_reset(1'b1);
        for (int c = 0; c < 10; c++) begin
            bus.REDIR_VALID = (c == 5);
            bus.REDIR_ADDR  = 30'h100;
            #1;
            if (c == 5) begin
                check("t3_ireq_r",  32'(bus.IREQ),      32'h0);
                check("t3_valid_r", 32'(bus.OUT_VALID), 32'h1);
                check("t3_pc_r",    32'(bus.OUT_PC),    32'h3);
            end else if (c == 6) begin
                check("t3_ireq_r1",  32'(bus.IREQ),      32'h1);
                check("t3_iaddr_r1", 32'(bus.IADDR),     32'h100);
                check("t3_valid_r1", 32'(bus.OUT_VALID), 32'h0);
            end else if (c == 7) begin
                check("t3_iaddr_r2", 32'(bus.IADDR),     32'h101);
                check("t3_valid_r2", 32'(bus.OUT_VALID), 32'h0);
            end else if (c == 8) begin
                check("t3_valid_r3", 32'(bus.OUT_VALID), 32'h1);
                check("t3_pc_r3",    32'(bus.OUT_PC),    32'h100);
                check("t3_instr_r3", bus.OUT_INSTR,      32'h100);
            end else if (c == 9) begin
                check("t3_pc_r4", 32'(bus.OUT_PC), 32'h101);
            end
            tick();
        end
        bus.REDIR_VALID = 1'b0;

        // Redirect and pop together on a full queue.
        do_reset(1'b0);
        for (int c = 0; c < 10; c++) begin
            bus.OUT_READY   = (c >= 6);
            bus.REDIR_VALID = (c == 6);
            bus.REDIR_ADDR  = 30'h2A;
            #1;
            if (c == 5) begin
                check("t4_ireq_full", 32'(bus.IREQ), 32'h0);
            end else if (c == 6) begin
                check("t4_valid_r", 32'(bus.OUT_VALID), 32'h1);
                check("t4_pc_r",    32'(bus.OUT_PC),    32'h0);
                check("t4_ireq_r",  32'(bus.IREQ),      32'h0);
            end else if (c == 7) begin
                check("t4_empty",    32'(bus.OUT_VALID), 32'h0);
                check("t4_ireq_r1",  32'(bus.IREQ),      32'h1);
                check("t4_iaddr_r1", 32'(bus.IADDR),     32'h2A);
            end else if (c == 8) begin
                check("t4_empty2", 32'(bus.OUT_VALID), 32'h0);
            end else if (c == 9) begin
                check("t4_valid_r3", 32'(bus.OUT_VALID), 32'h1);
                check("t4_pc_r3",    32'(bus.OUT_PC),    32'h2A);
            end
            tick();
        end
        bus.REDIR_VALID = 1'b0;

        // Back-to-back redirects, the last one targeting the top of the address space.
        do_reset(1'b1);
        for (int c = 0; c < 9; c++) begin
            bus.REDIR_VALID = (c == 3) || (c == 4);
            bus.REDIR_ADDR  = (c == 3) ? 30'h1234 : 30'h3FFF_FFFF;
            #1;
            if (c == 4) begin
                check("t5_ireq_r", 32'(bus.IREQ), 32'h0);
            end else if (c == 5) begin
                check("t5_ireq_top",  32'(bus.IREQ),      32'h1);
                check("t5_iaddr_top", 32'(bus.IADDR),     32'h3FFF_FFFF);
                check("t5_valid0",    32'(bus.OUT_VALID), 32'h0);
            end else if (c == 6) begin
                check("t5_iaddr_wrap", 32'(bus.IADDR),     32'h0);
                check("t5_valid1",     32'(bus.OUT_VALID), 32'h0);
            end else if (c == 7) begin
                check("t5_valid_top", 32'(bus.OUT_VALID), 32'h1);
                check("t5_pc_top",    32'(bus.OUT_PC),    32'h3FFF_FFFF);
            end else if (c == 8) begin
                check("t5_pc_wrap",    32'(bus.OUT_PC), 32'h0);
                check("t5_instr_wrap", bus.OUT_INSTR,   32'h0);
            end
            tick();
        end
        bus.REDIR_VALID = 1'b0;

        // Reset mid-operation with three queued entries and one fetch in flight.
        do_reset(1'b0);
        for (int c = 0; c < 10; c++) begin
            RST = (c == 4);
            #1;
            if (c == 4) begin
                check("t6_pre_valid", 32'(bus.OUT_VALID), 32'h1);
                check("t6_pre_ireq",  32'(bus.IREQ),      32'h0);
            end else if (c == 5) begin
                check("t6_valid", 32'(bus.OUT_VALID), 32'h0);
                check("t6_ireq",  32'(bus.IREQ),      32'h0);
                check("t6_iaddr", 32'(bus.IADDR),     32'h0);
                check("t6_pc",    32'(bus.OUT_PC),    32'h0);
                check("t6_instr", bus.OUT_INSTR,      32'h0);
            end else if (c == 6) begin
                check("t6_ireq_go", 32'(bus.IREQ),  32'h1);
                check("t6_iaddr0",  32'(bus.IADDR), 32'h0);
            end else if (c == 7) begin
                check("t6_iaddr1",  32'(bus.IADDR),     32'h1);
                check("t6_valid_e", 32'(bus.OUT_VALID), 32'h0);
            end else if (c == 8) begin
                check("t6_valid_f", 32'(bus.OUT_VALID), 32'h1);
                check("t6_pc_f",    32'(bus.OUT_PC),    32'h0);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
